coin_payout_ctrl: RTL and testbench

COIN_PAYOUT_CTRL -- requirements
Module: coin_payout_ctrl

---
 rtl/coin_payout_ctrl_pkg.sv | 21 ++
 rtl/coin_payout_ctrl_sync_edge_det.sv | 21 ++
 rtl/coin_payout_ctrl.sv | 121 ++++++++++++
 tb/tb_coin_payout_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_payout_ctrl_pkg.sv
// coin_payout_ctrl_pkg: shared slot-machine constants, FSM encodings and amount clamp helper
package coin_payout_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRIVE    = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_GAP      = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    localparam logic [6:0] MAX_AMT = 7'd99;

    localparam int DEF_PULSE_CYC   = 50;
    localparam int DEF_GAP_CYC     = 50;
    localparam int DEF_ACK_TIMEOUT = 1000;

    function automatic logic [6:0] clamp_amt(input logic [6:0] amt);
        return (amt > MAX_AMT) ? MAX_AMT : amt;
    endfunction

endpackage

// File: rtl/coin_payout_ctrl_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus rising-edge detector for the hopper coin-exit sensor
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sync_q, sync_d;

    // Shift the async input through two sync stages and one history stage
    always_comb sync_d = {sync_q[1:0], din};

    // Sync and history flops, cleared by reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/coin_payout_ctrl.sv
// coin_payout_ctrl: drives a coin hopper one pulse per coin, counts sensor acks, handles timeout and abort
module coin_payout_ctrl
    import coin_payout_ctrl_pkg::*;
#(
    parameter int PULSE_CYC   = DEF_PULSE_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PAY_REQ,
    input  logic [6:0] PAY_AMT,
    input  logic       HOPPER_ACK,
    input  logic       ABORT,
    output logic       HOPPER_DRV,
    output logic       PAY_BUSY,
    output logic       PAY_DONE,
    output logic       PAY_ERR,
    output logic [6:0] PAID_CNT,
    output logic [6:0] REMAIN
);

    // One timer serves both the ack timeout (from drive rise) and the gap length
    localparam int TMAX = (ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [6:0]    paid_q, paid_d, remain_q, remain_d;
    logic          acked_q, acked_d, err_q, err_d, drv_q, drv_d;
    logic          ack_edge, ack_take;

    sync_edge_det u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .din   (HOPPER_ACK),
        .rise  (ack_edge)
    );

    // Next-state, timer and coin accounting; an ack is booked before an abort takes effect
    always_comb begin
        state_d  = state_q;
        tmr_d    = (tmr_q == TW'(TMAX)) ? tmr_q : tmr_q + 1'b1;
        paid_d   = paid_q;
        remain_d = remain_q;
        acked_d  = acked_q;
        err_d    = err_q;
        ack_take = ack_edge && !acked_q && (state_q == ST_DRIVE || state_q == ST_WAIT_ACK);
        if (ack_take) begin
            acked_d  = 1'b1;
            remain_d = (remain_q == 7'd0) ? 7'd0 : remain_q - 7'd1;
            paid_d   = (paid_q >= MAX_AMT) ? MAX_AMT : paid_q + 7'd1;
        end
        if (ABORT && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tmr_d = '0;
                    if (PAY_REQ) begin
                        remain_d = clamp_amt(PAY_AMT);
                        paid_d   = 7'd0;
                        err_d    = 1'b0;
                        acked_d  = 1'b0;
                        state_d  = (clamp_amt(PAY_AMT) == 7'd0) ? ST_DONE : ST_DRIVE;
                    end
                end
                ST_DRIVE:
                    if (tmr_q == TW'(PULSE_CYC - 1)) begin
                        state_d = acked_d ? ST_GAP : ST_WAIT_ACK;
                        if (acked_d) tmr_d = '0;
                    end
                ST_WAIT_ACK:
                    if (ack_take) begin
                        state_d = ST_GAP;
                        tmr_d   = '0;
                    end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                ST_GAP:
                    if (tmr_q == TW'(GAP_CYC - 1)) begin
                        state_d = (remain_q != 7'd0) ? ST_DRIVE : ST_DONE;
                        tmr_d   = '0;
                        acked_d = 1'b0;
                    end
                default: state_d = ST_IDLE;
            endcase
        end
        drv_d = (state_d == ST_DRIVE);
    end

    // State registers; async reset drops the drive immediately
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            paid_q   <= 7'd0;
            remain_q <= 7'd0;
            acked_q  <= 1'b0;
            err_q    <= 1'b0;
            drv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            paid_q   <= paid_d;
            remain_q <= remain_d;
            acked_q  <= acked_d;
            err_q    <= err_d;
            drv_q    <= drv_d;
        end

    assign HOPPER_DRV = drv_q;
    assign PAY_BUSY   = (state_q != ST_IDLE);
    assign PAY_DONE   = (state_q == ST_DONE);
    assign PAY_ERR    = err_q;
    assign PAID_CNT   = paid_q;
    assign REMAIN     = remain_q;

endmodule

// File: tb/tb_coin_payout_ctrl.sv
// tb_coin_payout_ctrl: randomized payouts against a per-coin outcome model, scoreboard checked at completion
module tb_coin_payout_ctrl;

    localparam int PC = 4;
    localparam int GC = 3;
    localparam int AT = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PAY_REQ = 1'b0;
    logic [6:0] PAY_AMT = 7'd0;
    logic       HOPPER_ACK = 1'b0;
    logic       ABORT = 1'b0;
    logic       HOPPER_DRV, PAY_BUSY, PAY_DONE, PAY_ERR;
    logic [6:0] PAID_CNT, REMAIN;

    typedef struct {
        int paid;
        int remain;
        int err;
        int done;
        int pulses;
        int tmo;
    } exp_t;

    exp_t sb[$];
    int   plan[128];
    int   dly[128];
    int   coin_idx = 0;
    int   errors = 0;
    int   checks = 0;
    int   txn_done = 0;
    int   cyc = 0;
    int   m_pulses = 0;
    int   m_done = 0;
    int   err_dly = -1;
    int   hi_run = 0;
    int   low_run = 0;
    int   rise_cyc = 0;
    logic drv_prev = 1'b0;
    logic busy_prev = 1'b0;
    logic err_prev = 1'b0;

    always #5 CLK = ~CLK;

    coin_payout_ctrl #(.PULSE_CYC(PC), .GAP_CYC(GC), .ACK_TIMEOUT(AT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PAY_REQ    (PAY_REQ),
        .PAY_AMT    (PAY_AMT),
        .HOPPER_ACK (HOPPER_ACK),
        .ABORT      (ABORT),
        .HOPPER_DRV (HOPPER_DRV),
        .PAY_BUSY   (PAY_BUSY),
        .PAY_DONE   (PAY_DONE),
        .PAY_ERR    (PAY_ERR),
        .PAID_CNT   (PAID_CNT),
        .REMAIN     (REMAIN)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outcome of a payout from the coin plan: coins are paid in order until an abort or a silent coin
    function automatic exp_t model(input int amt, input int abort_at);
        exp_t e;
        int   n;
        n = (amt > 99) ? 99 : amt;
        e = '{paid: 0, remain: n, err: 0, done: 0, pulses: 0, tmo: 0};
        for (int i = 0; i < n; i++) begin
            e.pulses++;
            if (abort_at == i + 1) begin
                e.err = 1;
                return e;
            end
            if (plan[i] == 0) begin
                e.err = 1;
                e.tmo = 1;
                return e;
            end
            e.paid++;
            e.remain--;
        end
        e.done = 1;
        return e;
    endfunction

    // Hopper model: on each drive rise, emit zero, one or two sensor pulses after the planned delay
    initial begin
        int   p, d;
        logic seen;
        seen = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (HOPPER_DRV && !seen) begin
                p = plan[coin_idx];
                d = dly[coin_idx];
                coin_idx++;
                if (p != 0) begin
                    repeat (d) @(posedge CLK);
                    #2 HOPPER_ACK = 1'b1;
                    @(posedge CLK); #2 HOPPER_ACK = 1'b0;
                    if (p == 2) begin
                        @(posedge CLK); #2 HOPPER_ACK = 1'b1;
                        @(posedge CLK); #2 HOPPER_ACK = 1'b0;
                    end
                end
            end
            seen = HOPPER_DRV;
        end
    end

    // Monitor: pulse shape checks, and scoreboard compare whenever a payout ends
    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (!RST) begin
            drv_prev  = 1'b0;
            busy_prev = 1'b0;
            err_prev  = 1'b0;
        end else begin
            if (HOPPER_DRV) begin
                if (!drv_prev) begin
                    if (m_pulses > 0) chk("gap_len", (low_run >= GC) ? GC : low_run, GC);
                    m_pulses++;
                    hi_run   = 0;
                    rise_cyc = cyc;
                end
                hi_run++;
            end else begin
                if (drv_prev) begin
                    if (!PAY_ERR) chk("pulse_len", hi_run, PC);
                    low_run = 0;
                end
                low_run++;
            end
            if (PAY_DONE) m_done++;
            if (PAY_ERR && !err_prev) err_dly = cyc - rise_cyc;
            if (busy_prev && !PAY_BUSY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_end", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("paid_cnt", PAID_CNT, e.paid);
                    chk("remain", REMAIN, e.remain);
                    chk("pay_err", PAY_ERR, e.err);
                    chk("done_pulses", m_done, e.done);
                    chk("drive_pulses", m_pulses, e.pulses);
                    if (e.tmo) chk("timeout_cycle", err_dly, AT);
                end
                txn_done = 1;
            end
            drv_prev  = HOPPER_DRV;
            busy_prev = PAY_BUSY;
            err_prev  = PAY_ERR;
        end
    end

    task automatic run_txn(input int amt, input int abort_at, input int noack_at, input int dbl);
        int n, waited, aborted;
        n = (amt > 99) ? 99 : amt;
        for (int i = 0; i < 128; i++) begin
            plan[i] = (dbl != 0 && $urandom_range(0, 1) == 1) ? 2 : 1;
            dly[i]  = $urandom_range(1, 6);
        end
        if (noack_at > 0) plan[noack_at-1] = 0;
        coin_idx = 0;
        m_pulses = 0;
        m_done   = 0;
        err_dly  = -1;
        txn_done = 0;
        aborted  = 0;
        sb.push_back(model(amt, abort_at));
        PAY_AMT = 7'(amt);
        PAY_REQ = 1'b1;
        @(posedge CLK); #1;
        PAY_REQ = 1'b0;
        PAY_AMT = 7'($urandom);
        chk("remain_load", REMAIN, n);
        chk("busy_on_accept", PAY_BUSY, 1);
        waited = 0;
        while (txn_done == 0 && waited < 3000) begin
            if (abort_at > 0 && aborted == 0 && m_pulses == abort_at) begin
                ABORT = 1'b1;
                @(posedge CLK); #1;
                ABORT = 1'b0;
                aborted = 1;
                chk("abort_drv_low", HOPPER_DRV, 0);
                chk("abort_err", PAY_ERR, 1);
                chk("abort_idle", PAY_BUSY, 0);
            end else if (PAY_BUSY && $urandom_range(0, 7) == 0) begin
                PAY_AMT = 7'($urandom_range(1, 127));
                PAY_REQ = 1'b1;
                @(posedge CLK); #1;
                PAY_REQ = 1'b0;
            end else begin
                @(posedge CLK); #1;
            end
            waited++;
        end
        if (txn_done == 0) chk("txn_complete", 0, 1);
        repeat (12) @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_drv"}, HOPPER_DRV, 0);
        chk({tag, "_busy"}, PAY_BUSY, 0);
        chk({tag, "_done"}, PAY_DONE, 0);
        chk({tag, "_err"}, PAY_ERR, 0);
        chk({tag, "_paid"}, PAID_CNT, 0);
        chk({tag, "_remain"}, REMAIN, 0);
    endtask

    initial begin
        int n, ab, na, waited;
        #1 RST = 1'b0;
        #2 chk_reset_vals("reset");
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        run_txn(3, 0, 0, 0);
        run_txn(2, 0, 2, 0);
        run_txn(0, 0, 0, 0);
        run_txn(120, 0, 0, 0);
        run_txn(5, 2, 0, 0);
        run_txn(4, 0, 0, 1);
        for (int t = 0; t < 30; t++) begin
            n  = $urandom_range(0, 10);
            ab = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n) : 0;
            na = (n > 0 && ab == 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n) : 0;
            run_txn(n, ab, na, $urandom_range(0, 1));
        end
        chk("scoreboard_empty", sb.size(), 0);
        for (int i = 0; i < 128; i++) begin
            plan[i] = 1;
            dly[i]  = 3;
        end
        coin_idx = 0;
        PAY_AMT  = 7'd5;
        PAY_REQ  = 1'b1;
        @(posedge CLK); #1;
        PAY_REQ = 1'b0;
        waited = 0;
        while (!HOPPER_DRV && waited < 50) begin
            @(posedge CLK); #1;
            waited++;
        end
        chk("drive_before_reset", HOPPER_DRV, 1);
        @(posedge CLK); #3;
        RST = 1'b0;
        #1 chk_reset_vals("async_reset");
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (10) @(posedge CLK);
        #1 chk_reset_vals("after_reset");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
